// File: rtl/uart_ctrl.sv
// -----------------------------------------------------------------------------
// uart_ctrl -- init sequencer, two-requester TX arbiter and RX forwarder that
// sits in front of a byte-oriented UART core.
//
// Optional feature: define UART_CTRL_PKT_LOCK_EN to keep the TX grant with one
// requester until it hands over a byte flagged reqN_last. Without the macro the
// arbitration is plain per-byte round-robin and reqN_last is ignored.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   start, div_in       one-cycle (re)init pulse, bit-duration divisor sampled on it
//   init_done           high while the main FSM is in RUN
//   reqN_valid/data/last/ready (N=0,1)   TX requesters (ready is combinational)
//   rx_valid/rx_data/rx_ready            RX consumer
//   uc_rst_soft, uc_tx_en, uc_rx_en, uc_bit_duration, uc_tx_data,
//   uc_data_write_en, uc_data_read_en    core controls
//   uc_tx_ready, uc_rx_ready, uc_rx_data core status / received byte
// -----------------------------------------------------------------------------
module uart_ctrl #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] div_in,
  output logic             init_done,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  input  logic             rx_ready,
  output logic             uc_rst_soft,
  output logic             uc_tx_en,
  output logic             uc_rx_en,
  output logic [DIV_W-1:0] uc_bit_duration,
  output logic [7:0]       uc_tx_data,
  output logic             uc_data_write_en,
  output logic             uc_data_read_en,
  input  logic             uc_tx_ready,
  input  logic             uc_rx_ready,
  input  logic [7:0]       uc_rx_data
);

  typedef enum logic [1:0] {IDLE, SRST, EN, RUN}    main_state_e;
  typedef enum logic [1:0] {ARB, WR, GAP0, GAP1}    tx_state_e;
  typedef enum logic [1:0] {RIDLE, RGAP0, RGAP1}    rx_state_e;

  main_state_e      main_state_q, main_state_d;
  tx_state_e        tx_state_q, tx_state_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic             en_q, en_d;
  logic [DIV_W-1:0] bit_dur_q, bit_dur_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             ptr_q, ptr_d;         // 1: favour req1 when both are eligible

`ifdef UART_CTRL_PKT_LOCK_EN
  logic             lock_q, lock_d;       // grant held by owner_q mid-packet
  logic             owner_q, owner_d;
`else
  logic             unused_last;
  assign unused_last = req0_last ^ req1_last;
`endif

  logic elig0, elig1, grant_any, grant_sel, rx_fire;

  // ---------------------------------------------------------------- state regs
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset too, because every output, data included, must read 0 after rst.
      main_state_q <= IDLE;
      tx_state_q   <= ARB;
      rx_state_q   <= RIDLE;
      en_q         <= 1'b0;
      bit_dur_q    <= '0;
      tx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      ptr_q        <= 1'b0;
`ifdef UART_CTRL_PKT_LOCK_EN
      lock_q       <= 1'b0;
      owner_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      main_state_q <= main_state_d;
      tx_state_q   <= tx_state_d;
      rx_state_q   <= rx_state_d;
      en_q         <= en_d;
      bit_dur_q    <= bit_dur_d;
      tx_data_q    <= tx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      ptr_q        <= ptr_d;
`ifdef UART_CTRL_PKT_LOCK_EN
      lock_q       <= lock_d;
      owner_q      <= owner_d;
`endif
    end
  end

  // ------------------------------------------------------------ main next-state
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    main_state_d = main_state_q;
    if (start) begin
      main_state_d = SRST;
    end else begin
      case (main_state_q)
        SRST:    main_state_d = EN;
        EN:      main_state_d = RUN;
        default: main_state_d = main_state_q;
      endcase
    end
    // Enables latch on entering EN and stay up until rst.
    en_d      = en_q | (main_state_d == EN);
    bit_dur_d = start ? div_in : bit_dur_q;
  end

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    elig0 = req0_valid;
    elig1 = req1_valid;
`ifdef UART_CTRL_PKT_LOCK_EN
    if (lock_q) begin
      elig0 = req0_valid && !owner_q;
      elig1 = req1_valid &&  owner_q;
    end
`endif
    // A start in the same cycle abandons the slot, so nothing is accepted.
    grant_any = (main_state_q == RUN) && (tx_state_q == ARB) && uc_tx_ready &&
                !start && (elig0 || elig1);
    grant_sel = (elig0 && elig1) ? ptr_q : elig1;
  end

  // -------------------------------------------------------------- TX next-state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    ptr_d      = ptr_q;
`ifdef UART_CTRL_PKT_LOCK_EN
    lock_d     = lock_q;
    owner_d    = owner_q;
`endif
    if (start) begin
      tx_state_d = ARB;
      ptr_d      = 1'b0;
`ifdef UART_CTRL_PKT_LOCK_EN
      lock_d     = 1'b0;
`endif
    end else if (main_state_q == RUN) begin
      case (tx_state_q)
        ARB: if (grant_any) begin
          tx_state_d = WR;
          tx_data_d  = grant_sel ? req1_data : req0_data;
          ptr_d      = !grant_sel;
`ifdef UART_CTRL_PKT_LOCK_EN
          lock_d     = !(grant_sel ? req1_last : req0_last);
          owner_d    = grant_sel;
`endif
        end
        WR:      tx_state_d = GAP0;
        GAP0:    tx_state_d = GAP1;
        default: tx_state_d = ARB;
      endcase
    end
  end

  // -------------------------------------------------------------- RX next-state
  always_comb begin
    // Read only with an empty output slot; otherwise the byte waits in the core.
    rx_fire    = (main_state_q == RUN) && (rx_state_q == RIDLE) && uc_rx_ready &&
                 !rx_valid_q && !start;
    rx_state_d = rx_state_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (start) begin
      rx_state_d = RIDLE;
      rx_valid_d = 1'b0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      case (rx_state_q)
        RIDLE: if (rx_fire) begin
          rx_state_d = RGAP0;
          rx_valid_d = 1'b1;
          rx_data_d  = uc_rx_data;
        end
        RGAP0:   rx_state_d = RGAP1;
        default: rx_state_d = RIDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------- outputs
  always_comb begin
    init_done        = (main_state_q == RUN);
    uc_rst_soft      = (main_state_q == SRST);
    uc_data_write_en = (tx_state_q == WR) && !start;
    uc_data_read_en  = rx_fire;
    req0_ready       = grant_any && !grant_sel;
    req1_ready       = grant_any &&  grant_sel;
  end

  assign uc_tx_en        = en_q;
  assign uc_rx_en        = en_q;
  assign uc_bit_duration = bit_dur_q;
  assign uc_tx_data      = tx_data_q;
  assign rx_valid        = rx_valid_q;
  assign rx_data         = rx_data_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl -- scoreboard bench for uart_ctrl with a behavioural loopback
// UART core. Stimulus pushes expected bytes into exp_q; an independent monitor
// pops and compares on every rx_valid/rx_ready handshake.
// -----------------------------------------------------------------------------
module tb_uart_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_item_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] div_in;
  logic        init_done;
  logic        req0_valid, req0_last, req0_ready;
  logic [7:0]  req0_data;
  logic        req1_valid, req1_last, req1_ready;
  logic [7:0]  req1_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        uc_rst_soft, uc_tx_en, uc_rx_en;
  logic [31:0] uc_bit_duration;
  logic [7:0]  uc_tx_data;
  logic        uc_data_write_en, uc_data_read_en;
  logic        uc_tx_ready = 1'b1;
  logic        uc_rx_ready = 1'b0;
  logic [7:0]  uc_rx_data  = 8'h00;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  tx_item_t    tx_q0[$];
  tx_item_t    tx_q1[$];

  int          cyc = 0;
  int          write_cnt = 0, read_cnt = 0, wr_width = 0, last_read_cyc = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_start = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  uart_ctrl #(.DIV_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .div_in(div_in), .init_done(init_done),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .uc_rst_soft(uc_rst_soft), .uc_tx_en(uc_tx_en), .uc_rx_en(uc_rx_en),
    .uc_bit_duration(uc_bit_duration), .uc_tx_data(uc_tx_data),
    .uc_data_write_en(uc_data_write_en), .uc_data_read_en(uc_data_read_en),
    .uc_tx_ready(uc_tx_ready), .uc_rx_ready(uc_rx_ready), .uc_rx_data(uc_rx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Loopback core: written bytes go straight to its receive FIFO; the
  // transmitter stays busy for a few cycles after each write.
  logic [7:0] core_q[$];
  int         tx_busy = 0;
  always @(posedge clk) begin
    if (rst || uc_rst_soft) begin
      core_q.delete();
      tx_busy     <= 0;
      uc_tx_ready <= 1'b1;
    end else begin
      if (uc_data_read_en && core_q.size() != 0) void'(core_q.pop_front());
      if (uc_data_write_en) core_q.push_back(uc_tx_data);
      if (uc_data_write_en) tx_busy <= 5;
      else if (tx_busy != 0) tx_busy <= tx_busy - 1;
      uc_tx_ready <= !uc_data_write_en && (tx_busy <= 1);
    end
    uc_rx_ready <= core_q.size() != 0;
    uc_rx_data  <= (core_q.size() != 0) ? core_q[0] : 8'h00;
  end

  // Monitor: scoreboard compare, handshake stability, pulse widths, grant rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte (cycle %0d)", rx_data, cyc);
        end else begin
          check("rx_data", rx_data, exp_q.pop_front());
        end
      end
      if (prev_valid && !prev_start) begin
        if (prev_hs) check("rx_valid_clear", rx_valid, 1'b0);
        else begin
          check("rx_valid_hold", rx_valid, 1'b1);
          check("rx_data_hold", rx_data, prev_data);
        end
      end
      if (uc_data_write_en) begin
        if (wr_width == 0) write_cnt <= write_cnt + 1;
        wr_width <= wr_width + 1;
      end else if (wr_width != 0) begin
        check("wr_pulse_width", wr_width, 1);
        wr_width <= 0;
      end
      if (uc_data_read_en) begin
        read_cnt      <= read_cnt + 1;
        last_read_cyc <= cyc;
      end
      if (req0_ready || req1_ready) begin
        check("ready_onehot", req0_ready & req1_ready, 1'b0);
        check("ready_in_wr", uc_data_write_en, 1'b0);
      end
      prev_valid <= rx_valid;
      prev_hs    <= rx_valid && rx_ready;
      prev_start <= start;
      prev_data  <= rx_data;
    end
  end

  task automatic check_reset_outputs();
    check("rst_init_done", init_done, 1'b0);
    check("rst_soft", uc_rst_soft, 1'b0);
    check("rst_tx_en", uc_tx_en, 1'b0);
    check("rst_rx_en", uc_rx_en, 1'b0);
    check("rst_bit_duration", uc_bit_duration, 32'd0);
    check("rst_tx_data", uc_tx_data, 8'h00);
    check("rst_write_en", uc_data_write_en, 1'b0);
    check("rst_read_en", uc_data_read_en, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_req0_ready", req0_ready, 1'b0);
  endtask

  // Pulse start for one cycle and follow SRST -> EN -> RUN.
  task automatic do_init(input logic [31:0] div, input bit fresh);
    @(posedge clk); #1;
    start  = 1'b1;
    div_in = div;
    @(posedge clk); #1;
    start  = 1'b0;
    div_in = 32'd0;
    @(negedge clk);
    check("srst_soft", uc_rst_soft, 1'b1);
    check("srst_init_done", init_done, 1'b0);
    check("srst_rx_valid", rx_valid, 1'b0);
    check("srst_write_en", uc_data_write_en, 1'b0);
    check("srst_read_en", uc_data_read_en, 1'b0);
    check("srst_bit_duration", uc_bit_duration, div);
    if (fresh) check("srst_tx_en", uc_tx_en, 1'b0);
    @(negedge clk);
    check("en_soft", uc_rst_soft, 1'b0);
    check("en_tx_en", uc_tx_en, 1'b1);
    check("en_rx_en", uc_rx_en, 1'b1);
    check("en_init_done", init_done, 1'b0);
    check("en_write_en", uc_data_write_en, 1'b0);
    @(negedge clk);
    check("run_init_done", init_done, 1'b1);
    check("run_bit_duration", uc_bit_duration, div);
  endtask

  // Present the first n entries of requester k's item queue, one per grant.
  task automatic drive_req(input int k, input int n);
    tx_item_t it;
    int       waited;
    logic     got;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      it = (k == 0) ? tx_q0[i] : tx_q1[i];
      if (k == 0) begin req0_valid = 1'b1; req0_data = it.data; req0_last = it.last; end
      else        begin req1_valid = 1'b1; req1_data = it.data; req1_last = it.last; end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 200) begin
        @(negedge clk);
        got = (k == 0) ? req0_ready : req1_ready;
        waited++;
      end
      if (k == 0) check("req0_grant", got, 1'b1);
      else        check("req1_grant", got, 1'b1);
      if (!got) break;
      @(posedge clk); #1;
    end
    if (k == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, wb, r1, hs55, n;
    logic [7:0] lock_exp [5];

    // Reset with start and a requester active: rst must win.
    rst = 1'b1; start = 1'b1; div_in = 32'd7; rx_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h5A; req0_last = 1'b1;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; req0_valid = 1'b0; div_in = 32'd0;
    repeat (2) @(negedge clk);
    check("idle_init_done", init_done, 1'b0);
    check("idle_soft", uc_rst_soft, 1'b0);

    // Init sequence, divisor 100.
    do_init(32'd100, 1'b1);

    // Loopback 0x00..0xFF through req0.
    tx_q0.delete();
    for (int i = 0; i < 256; i++) begin
      tx_q0.push_back(tx_item_t'{data: 8'(i), last: 1'b1});
      exp_q.push_back(8'(i));
    end
    drive_req(0, 256);
    wait_drain();

    // Both requesters continuously valid: strict alternation from req0.
    do_init(32'd100, 1'b0);
    tx_q0.delete(); tx_q1.delete();
    for (int i = 0; i < 2; i++) begin
      tx_q0.push_back(tx_item_t'{data: 8'hA0, last: 1'b1});
      tx_q1.push_back(tx_item_t'{data: 8'hB1, last: 1'b1});
    end
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1);
    fork
      drive_req(0, 2);
      drive_req(1, 2);
    join
    wait_drain();

    // Three-byte packet from req0 against a two-byte stream from req1.
    do_init(32'd100, 1'b0);
    tx_q0.delete(); tx_q1.delete();
    tx_q0.push_back(tx_item_t'{data: 8'h10, last: 1'b0});
    tx_q0.push_back(tx_item_t'{data: 8'h11, last: 1'b0});
    tx_q0.push_back(tx_item_t'{data: 8'h12, last: 1'b1});
    tx_q1.push_back(tx_item_t'{data: 8'h20, last: 1'b1});
    tx_q1.push_back(tx_item_t'{data: 8'h21, last: 1'b1});
`ifdef UART_CTRL_PKT_LOCK_EN
    lock_exp = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21};
`else
    lock_exp = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12};
`endif
    foreach (lock_exp[i]) exp_q.push_back(lock_exp[i]);
    fork
      drive_req(0, 3);
      drive_req(1, 2);
    join
    wait_drain();

    // Consumer stalled while two bytes arrive: one read, second waits in core.
    do_init(32'd100, 1'b0);
    rx_ready = 1'b0;
    rb = read_cnt;
    tx_q0.delete();
    tx_q0.push_back(tx_item_t'{data: 8'h55, last: 1'b1});
    tx_q0.push_back(tx_item_t'{data: 8'h66, last: 1'b1});
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    drive_req(0, 2);
    repeat (12) @(negedge clk);
    check("stall_read_count", read_cnt - rb, 1);
    check("stall_rx_valid", rx_valid, 1'b1);
    check("stall_rx_data", rx_data, 8'h55);
    r1 = last_read_cyc;
    @(posedge clk); #1;
    rx_ready = 1'b1;
    @(negedge clk);
    hs55 = cyc;
    n = 0;
    while (read_cnt - rb < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("second_read_seen", read_cnt - rb, 2);
    check("second_read_after_hs", last_read_cyc > hs55, 1'b1);
    check("second_read_gap", (last_read_cyc - r1) >= 3, 1'b1);
    wait_drain();

    // start during the TX gap: byte in flight and held rx byte are abandoned.
    rx_ready = 1'b0;
    tx_q0.delete();
    tx_q0.push_back(tx_item_t'{data: 8'h11, last: 1'b1});
    drive_req(0, 1);
    n = 0;
    while (!rx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("held_rx_data", rx_data, 8'h11);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h3C; req0_last = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req0_ready && n < 50);
    check("restart_grant", req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wb = write_cnt;
    rb = read_cnt;
    do_init(32'd100, 1'b0);
    repeat (10) @(negedge clk);
    check("restart_write_count", write_cnt, wb + 1);
    check("restart_read_count", read_cnt, rb);
    check("restart_rx_valid", rx_valid, 1'b0);
    rx_ready = 1'b1;
    tx_q0.delete();
    tx_q0.push_back(tx_item_t'{data: 8'h5A, last: 1'b1});
    exp_q.push_back(8'h5A);
    drive_req(0, 1);
    wait_drain();

    // Reset from a busy state clears every output, data included.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; req0_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
